// File: rtl/data_mem_wait.sv
// data_mem_wait: single-port 32-bit word memory that answers each request after a programmable number of wait cycles.
// Build option DATA_MEM_RANDOM_LATENCY_EN adds 0..3 pseudo-random extra wait cycles per request.
module data_mem_wait #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wd_i,
  output logic [31:0] mem_rd_o,
  output logic        mem_ready_o
);
  // state | meaning
  // IDLE  | waiting for mem_req_i; request fields captured on acceptance
  // WAIT  | counting down the effective latency
  // RESP  | one-cycle ready; write commits here, read data already loaded

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_eff_lat;
  logic            w_accept;

  logic            r_we;
  logic [3:0]      r_be;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wd;
  logic [31:0]     r_rd;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [AW-1:0]   w_idx_in;
  logic [AW-1:0]   w_idx_sel;
  logic            w_we_sel;
  logic            w_load_rd;
  logic            w_unused_addr;

  assign w_idx_in      = mem_addr_i[AW+1:2];
  assign w_unused_addr = ^{mem_addr_i[31:AW+2], mem_addr_i[1:0]};

`ifdef DATA_MEM_RANDOM_LATENCY_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, stepped once per accepted request
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_lfsr <= 8'hA5;
    end else if (w_accept) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_eff_lat = CW'(LATENCY) + {3'b000, r_lfsr[1:0]};
`else
  assign w_eff_lat = CW'(LATENCY);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = w_eff_lat;
          w_state_nxt = (w_eff_lat == '0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - CW'(1);
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_we  <= mem_we_i;
      r_be  <= mem_be_i;
      r_idx <= w_idx_in;
      r_wd  <= mem_wd_i;
    end
  end

  // A reset in the RESP cycle must suppress the commit, so rst_i gates the write.
  always_ff @(posedge clk_i) begin
    if (rst_i && (r_state == S_RESP) && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wd[8*b +: 8];
        end
      end
    end
  end

  // With zero latency RESP is entered straight from IDLE, before the capture registers hold the request.
  assign w_we_sel  = (r_state == S_IDLE) ? mem_we_i : r_we;
  assign w_idx_sel = (r_state == S_IDLE) ? w_idx_in : r_idx;
  assign w_load_rd = (w_state_nxt == S_RESP) && (r_state != S_RESP) && !w_we_sel;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rd <= '0;
    end else if (w_load_rd) begin
      r_rd <= r_mem[w_idx_sel];
    end
  end

  assign mem_rd_o    = r_rd;
  assign mem_ready_o = (r_state == S_RESP);

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed bench for data_mem_wait: one instance at LATENCY=2, one at LATENCY=0 for back-to-back traffic.
module tb_data_mem_wait;

`ifdef DATA_MEM_RANDOM_LATENCY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT_MIN = 3;
  localparam int LAT_MAX = 3 + EXTRA;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wd, a_rd;
  logic        a_rdy;
  logic        b_req, b_we;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wd, b_rd;
  logic        b_rdy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_wait #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(a_req), .mem_we_i(a_we), .mem_be_i(a_be),
    .mem_addr_i(a_addr), .mem_wd_i(a_wd), .mem_rd_o(a_rd), .mem_ready_o(a_rdy)
  );

  data_mem_wait #(.DEPTH_WORDS(1024), .LATENCY(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .mem_req_i(b_req), .mem_we_i(b_we), .mem_be_i(b_be),
    .mem_addr_i(b_addr), .mem_wd_i(b_wd), .mem_rd_o(b_rd), .mem_ready_o(b_rdy)
  );

  // Issues one request on instance A, holds it until ready, then samples ready one cycle later.
  task automatic xfer_a(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic rdy_after);
    a_we = we; a_be = be; a_addr = addr; a_wd = wd; a_req = 1'b1;
    lat = -1; rd = '0; rdy_after = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (a_rdy) begin
        lat = c;
        rd  = a_rd;
        break;
      end
    end
    a_req = 1'b0;
    if (lat > 0) begin
      @(posedge clk); #1;
      rdy_after = a_rdy;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_we = 0; a_be = 0; a_addr = 0; a_wd = 0;
    b_we = 0; b_be = 0; b_addr = 0; b_wd = 0;
    apply_reset();
    n_vec++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL rst_a_ready: got %b want 0", a_rdy); end
    n_vec++; if (a_rd !== 32'h0) begin n_err++; $display("FAIL rst_a_rd: got %h want 00000000", a_rd); end
    n_vec++; if (b_rdy !== 1'b0) begin n_err++; $display("FAIL rst_b_ready: got %b want 0", b_rdy); end
    n_vec++; if (b_rd !== 32'h0) begin n_err++; $display("FAIL rst_b_rd: got %h want 00000000", b_rd); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic ra;
    xfer_a(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd, ra);
    n_vec++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_err++; $display("FAIL wr_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    n_vec++; if (ra !== 1'b0) begin n_err++; $display("FAIL wr_pulse_width: ready after pulse %b want 0", ra); end
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL wr_rd_hold: got %h want 00000000", rd); end
    xfer_a(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, ra);
    n_vec++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_err++; $display("FAIL rd_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    n_vec++; if (ra !== 1'b0) begin n_err++; $display("FAIL rd_pulse_width: ready after pulse %b want 0", ra); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd; logic ra;
    xfer_a(1'b1, 4'hF, 32'h20, 32'h11223344, lat, rd, ra);
    n_vec++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL bl_rd_hold: got %h want deadbeef", rd); end
    xfer_a(1'b1, 4'b1000, 32'h20, 32'hAA000000, lat, rd, ra);
    xfer_a(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, ra);
    n_vec++; if (rd !== 32'hAA223344) begin n_err++; $display("FAIL bl_byte3: got %h want aa223344", rd); end
    xfer_a(1'b1, 4'b0011, 32'h20, 32'h55555555, lat, rd, ra);
    xfer_a(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, ra);
    n_vec++; if (rd !== 32'hAA225555) begin n_err++; $display("FAIL bl_half: got %h want aa225555", rd); end
  endtask

  task automatic test_be_zero();
    int lat; logic [31:0] rd; logic ra;
    xfer_a(1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, lat, rd, ra);
    n_vec++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_err++; $display("FAIL be0_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    xfer_a(1'b0, 4'h0, 32'h20, 32'h0, lat, rd, ra);
    n_vec++; if (rd !== 32'hAA225555) begin n_err++; $display("FAIL be0_data: got %h want aa225555", rd); end
  endtask

  task automatic test_alias();
    int lat; logic [31:0] rd; logic ra;
    xfer_a(1'b1, 4'hF, 32'h1010, 32'hCAFEF00D, lat, rd, ra);
    xfer_a(1'b0, 4'h0, 32'h0010, 32'h0, lat, rd, ra);
    n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL alias_wrap: got %h want cafef00d", rd); end
    xfer_a(1'b0, 4'h0, 32'h0013, 32'h0, lat, rd, ra);
    n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL alias_lowbits: got %h want cafef00d", rd); end
  endtask

  task automatic test_ignore_changes();
    int lat; logic [31:0] rd; logic ra;
    lat = -1; rd = '0;
    a_we = 1'b1; a_be = 4'hF; a_addr = 32'h30; a_wd = 32'h12345678; a_req = 1'b1;
    @(posedge clk); #1;
    a_we = 1'b0; a_be = 4'h0; a_addr = 32'h34; a_wd = 32'h0; a_req = 1'b0;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (a_rdy) begin lat = c; rd = a_rd; break; end
    end
    n_vec++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_err++; $display("FAIL ign_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    n_vec++; if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL ign_rd_hold: got %h want cafef00d", rd); end
    @(posedge clk); #1;
    xfer_a(1'b0, 4'h0, 32'h30, 32'h0, lat, rd, ra);
    n_vec++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL ign_data: got %h want 12345678", rd); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic ra; logic seen;
    xfer_a(1'b1, 4'hF, 32'h40, 32'hAAAA5555, lat, rd, ra);
    a_we = 1'b1; a_be = 4'hF; a_addr = 32'h40; a_wd = 32'h0; a_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; a_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = a_rdy;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | a_rdy;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", seen); end
    n_vec++; if (a_rd !== 32'h0) begin n_err++; $display("FAIL abort_rd_clr: got %h want 00000000", a_rd); end
    xfer_a(1'b0, 4'h0, 32'h40, 32'h0, lat, rd, ra);
    n_vec++; if (lat < LAT_MIN || lat > LAT_MAX) begin n_err++; $display("FAIL abort_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    n_vec++; if (rd !== 32'hAAAA5555) begin n_err++; $display("FAIL abort_data: got %h want aaaa5555", rd); end
  endtask

  task automatic test_back_to_back();
    logic        t_we   [4];
    logic [31:0] t_addr [4];
    logic [31:0] t_wd   [4];
    logic [31:0] t_exp  [4];
    int          rdy_cyc [4];
    int          idx;
    logic        prev_rdy;
    t_we[0] = 1'b1; t_addr[0] = 32'h60; t_wd[0] = 32'hA1A1A1A1; t_exp[0] = 32'h0;
    t_we[1] = 1'b1; t_addr[1] = 32'h64; t_wd[1] = 32'hB2B2B2B2; t_exp[1] = 32'h0;
    t_we[2] = 1'b0; t_addr[2] = 32'h60; t_wd[2] = 32'h0;        t_exp[2] = 32'hA1A1A1A1;
    t_we[3] = 1'b0; t_addr[3] = 32'h64; t_wd[3] = 32'h0;        t_exp[3] = 32'hB2B2B2B2;
    for (int i = 0; i < 4; i++) rdy_cyc[i] = -1;
    idx = 0; prev_rdy = 1'b0;
    b_we = t_we[0]; b_be = 4'hF; b_addr = t_addr[0]; b_wd = t_wd[0]; b_req = 1'b1;
    for (int c = 1; c <= 60 && idx < 4; c++) begin
      @(posedge clk); #1;
      if (b_rdy) begin
        n_vec++; if (prev_rdy) begin n_err++; $display("FAIL b2b_gap: ready high two cycles in a row at cycle %0d", c); end
        n_vec++; if (b_rd !== t_exp[idx]) begin n_err++; $display("FAIL b2b_rd%0d: got %h want %h", idx, b_rd, t_exp[idx]); end
        rdy_cyc[idx] = c;
        idx++;
        if (idx < 4) begin
          b_we = t_we[idx]; b_addr = t_addr[idx]; b_wd = t_wd[idx];
        end else begin
          b_req = 1'b0;
        end
      end
      prev_rdy = b_rdy;
    end
    b_req = 1'b0;
    n_vec++; if (idx !== 4) begin n_err++; $display("FAIL b2b_timeout: completed %0d want 4", idx); end
`ifndef DATA_MEM_RANDOM_LATENCY_EN
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (rdy_cyc[i] !== 2*i + 1) begin n_err++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, rdy_cyc[i], 2*i + 1); end
    end
`endif
    @(posedge clk); #1;
  endtask

`ifdef DATA_MEM_RANDOM_LATENCY_EN
  task automatic test_random_latency();
    int lat; logic [31:0] rd; logic ra;
    int seq [256];
    apply_reset(); rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      xfer_a(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, ra);
      seq[i] = lat;
      n_vec++;
      if (lat < 3 || lat > 6) begin n_err++; $display("FAIL rnd_range%0d: got %0d want 3..6", i, lat); end
    end
    apply_reset(); rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      xfer_a(1'b0, 4'h0, 32'h10, 32'h0, lat, rd, ra);
      n_vec++;
      if (lat !== seq[i]) begin n_err++; $display("FAIL rnd_repeat%0d: got %0d want %0d", i, lat, seq[i]); end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_be_zero();
    test_alias();
    test_ignore_changes();
    test_reset_abort();
    test_back_to_back();
`ifdef DATA_MEM_RANDOM_LATENCY_EN
    test_random_latency();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in the array (power of two, at least 4).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles inserted between request acceptance and response (range 0..15).
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 mem_req_i  input  1  request; held high by the requester until mem_ready_o.
REQ-006 mem_we_i  input  1  1 = write, 0 = read.
REQ-007 mem_be_i  input  4  byte enables for writes; bit n enables byte lane n.
REQ-008 mem_addr_i  input  32  byte address.
REQ-009 mem_wd_i  input  32  write data, lane-replicated by the requester.
REQ-010 mem_rd_o  output  32  read data, valid while mem_ready_o is high for a read.
REQ-011 mem_ready_o  output  1  one-cycle completion pulse.

Function
REQ-012 Word index SHALL be mem_addr_i[log2(DEPTH_WORDS)+1:2]; address bits [1:0] and all higher bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 IDLE with mem_req_i=1 SHALL capture we, be, addr and wd, then go to WAIT when the effective latency is greater than 0, or to RESP when it is 0.
REQ-015 WAIT SHALL decrement a wait counter each cycle and go to RESP in the cycle after the counter reaches 1; the counter is loaded with the effective latency at acceptance.
REQ-016 RESP SHALL drive mem_ready_o=1 for exactly one cycle, then return to IDLE.
REQ-017 mem_ready_o SHALL be 0 in IDLE and WAIT.
REQ-018 Latency: mem_ready_o SHALL rise exactly LATENCY+1 cycles after the first cycle mem_req_i is high in IDLE.
REQ-019 LATENCY=0 SHALL give ready in the cycle directly after the request.
REQ-020 Request inputs SHALL be sampled only at acceptance; changes or a dropped mem_req_i during WAIT or RESP SHALL be ignored, and the transaction completes with captured values.
REQ-021 mem_req_i still high during RESP SHALL NOT start a new transaction.
REQ-022 mem_req_i high in the IDLE cycle following RESP SHALL be accepted as a new request (back-to-back).
REQ-023 Writes SHALL update only byte lanes with be=1, in the RESP cycle.
REQ-024 Writes SHALL leave mem_rd_o unchanged.
REQ-025 Reads SHALL load mem_rd_o from the array on entry to RESP.
REQ-026 mem_rd_o SHALL hold its value until the next read response.
REQ-027 A write with be=0000 SHALL complete with normal timing and change no data.
REQ-028 A read following a write to the same word SHALL return the updated data.

Reset
REQ-029 While rst_i=0 at posedge, the FSM SHALL go to IDLE, and the counter, mem_ready_o and mem_rd_o SHALL be set to 0.
REQ-030 Reset during WAIT or RESP SHALL abort the transaction: no write is performed and no ready pulse is produced.
REQ-031 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-032 With macro DATA_MEM_RANDOM_LATENCY_EN defined, an 8-bit LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) SHALL advance once per accepted request, and its bits [1:0] (0..3) SHALL be added to LATENCY as the effective latency.
REQ-033 Without DATA_MEM_RANDOM_LATENCY_EN, the effective latency SHALL equal LATENCY and no LFSR logic SHALL exist.

Verification
REQ-034 LATENCY=2: write 32'hDEADBEEF, be=1111, addr 0x10 -> ready pulses 3 cycles after req; then read addr 0x10 -> ready after 3 cycles with rd=32'hDEADBEEF.
REQ-035 Byte write 0xAA000000 with be=1000 to word holding 0x11223344, then read -> rd=0xAA223344; halfword be=0011 data 0x5555 -> 0xAA225555.
REQ-036 LATENCY=0, requester holds req until ready and reissues immediately -> ready every 2nd cycle and no duplicate write from req held in RESP.
REQ-037 Address 0x1010 with DEPTH_WORDS=1024 aliases 0x0010 -> reading 0x0010 returns data written to 0x1010.
REQ-038 rst_i=0 during WAIT of a write -> no ready pulse, target word unchanged, next request has full latency.
REQ-039 DATA_MEM_RANDOM_LATENCY_EN defined -> 256 reads, each latency within LATENCY+1..LATENCY+4 cycles, and the sequence is repeatable after reset.
